// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing, IR latch,
// datapath strobes and a memory-handshake watchdog that parks in HALT.
module multicycle_control #(
  parameter int IW         = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] mem_instr,
  input  logic          mem_ready,
  input  logic          cond,
  output logic [5:0]    opcode,
  output logic [IW-1:0] ir,
  output logic          ir_write,
  output logic          pc_write,
  output logic [1:0]    pc_src,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_addr_sel,
  output logic [1:0]    alu_src_b,
  output logic          reg_write,
  output logic [1:0]    wb_sel,
  output logic [2:0]    state,
  output logic          illegal_op,
  output logic          bus_error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t     st;
  logic [7:0] wcnt;
  logic [5:0] op;

  logic is_rr;
  logic is_imm;
  logic is_br;
  logic is_jmp;
  logic is_jal;
  logic is_ld;
  logic is_st;
  logic is_def;
  logic expire;

  assign op     = ir[IW-1:IW-6];
  assign state  = st;

  assign is_rr  = op[5:3] == 3'b010;
  assign is_br  = op[5:2] == 4'b1000;
  assign is_jmp = op == 6'b000001;
  assign is_jal = op == 6'b000010;
  assign is_imm = (op[5:3] == 3'b110 && op[2:1] != 2'b00)
                || op == 6'b111001
                || op == 6'b111010;
  assign is_ld  = op == 6'b111011 || op == 6'b111101;
  assign is_st  = op == 6'b111100 || op == 6'b111110;
  assign is_def = is_rr | is_imm | is_br | is_jmp
                | is_jal | is_ld | is_st;

  // A ready in the limit cycle still completes the access normally.
  assign expire = !mem_ready
                && (wcnt == 8'(WAIT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= S_FETCH;
      ir        <= '0;
      wcnt      <= '0;
      bus_error <= 1'b0;
    end else begin
      unique case (st)
        S_FETCH: begin
          if (mem_ready) begin
            ir   <= mem_instr;
            st   <= S_DECODE;
            wcnt <= '0;
          end else if (expire) begin
            bus_error <= 1'b1;
            st        <= S_HALT;
            wcnt      <= '0;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_DECODE: begin
          wcnt <= '0;
          st   <= is_def ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          wcnt <= '0;
          if (is_rr || is_imm) begin
            st <= S_WB;
          end else if (is_ld || is_st) begin
            st <= S_MEM;
          end else begin
            st <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            st   <= is_ld ? S_WB : S_FETCH;
            wcnt <= '0;
          end else if (expire) begin
            bus_error <= 1'b1;
            st        <= S_HALT;
            wcnt      <= '0;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_WB: begin
          wcnt <= '0;
          st   <= S_FETCH;
        end
        S_HALT: begin
          wcnt <= '0;
          st   <= S_HALT;
        end
        default: begin
          wcnt <= '0;
          st   <= S_FETCH;
        end
      endcase
    end
  end

  // Strobes decode from state+IR; reset forces them all low.
  always_comb begin
    opcode       = 6'b000000;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_b    = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    illegal_op   = 1'b0;
    if (rst_n) begin
      unique case (st)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          opcode     = op;
          illegal_op = !is_def && (op != 6'b000000);
        end
        S_EXEC: begin
          opcode = op;
          unique case (1'b1)
            is_rr: alu_src_b = 2'b00;
            is_imm, is_ld, is_st: alu_src_b = 2'b10;
            is_br: begin
              pc_write = cond;
              pc_src   = 2'b01;
            end
            is_jmp: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
            is_jal: begin
              pc_write  = 1'b1;
              pc_src    = 2'b10;
              reg_write = 1'b1;
              wb_sel    = 2'b10;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          opcode       = op;
          mem_addr_sel = 1'b1;
          mem_read     = is_ld;
          mem_write    = is_st;
        end
        S_WB: begin
          opcode    = op;
          reg_write = 1'b1;
          wb_sel    = is_ld ? 2'b01 : 2'b00;
        end
        S_HALT: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed corner cases plus random
// instruction streams checked against a per-instruction reference model.
module tb_multicycle_control;

  localparam int IW = 16;
  localparam int WL = 4;

  localparam int C_NOOP = 0;
  localparam int C_ILL  = 1;
  localparam int C_RR   = 2;
  localparam int C_IMM  = 3;
  localparam int C_BR   = 4;
  localparam int C_J    = 5;
  localparam int C_JAL  = 6;
  localparam int C_LD   = 7;
  localparam int C_ST   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] mem_instr = '0;
  logic          mem_ready = 1'b0;
  logic          cond = 1'b0;
  logic [5:0]    opcode;
  logic [IW-1:0] ir;
  logic          ir_write;
  logic          pc_write;
  logic [1:0]    pc_src;
  logic          mem_read;
  logic          mem_write;
  logic          mem_addr_sel;
  logic [1:0]    alu_src_b;
  logic          reg_write;
  logic [1:0]    wb_sel;
  logic [2:0]    state;
  logic          illegal_op;
  logic          bus_error;

  int tests = 0;
  int fails = 0;

  logic [5:0] defs [16] = '{
    6'b000001, 6'b000010, 6'b010010, 6'b010111,
    6'b100000, 6'b100011, 6'b110010, 6'b110111,
    6'b111001, 6'b111010, 6'b111011, 6'b111101,
    6'b111100, 6'b111110, 6'b000000, 6'b010000
  };

  always #5 clk = ~clk;

  multicycle_control #(
    .IW(IW),
    .WAIT_LIMIT(WL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .cond(cond),
    .opcode(opcode),
    .ir(ir),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr_sel(mem_addr_sel),
    .alu_src_b(alu_src_b),
    .reg_write(reg_write),
    .wb_sel(wb_sel),
    .state(state),
    .illegal_op(illegal_op),
    .bus_error(bus_error)
  );

  function automatic int cls_of(logic [5:0] op);
    int v;
    v = int'(op);
    if (v == 0) return C_NOOP;
    if (v == 1) return C_J;
    if (v == 2) return C_JAL;
    if (v >= 16 && v <= 23) return C_RR;
    if (v >= 32 && v <= 35) return C_BR;
    if ((v >= 50 && v <= 55) || v == 57 || v == 58) return C_IMM;
    if (v == 59 || v == 61) return C_LD;
    if (v == 60 || v == 62) return C_ST;
    return C_ILL;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // sv = {ir_write,pc_write,mem_read,mem_write,reg_write,illegal_op,bus_error}
  task automatic expect_cycle(input string tag,
                              input logic [2:0] st,
                              input logic [6:0] sv);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_strobes"},
        32'({ir_write, pc_write, mem_read, mem_write,
             reg_write, illegal_op, bus_error}),
        32'(sv));
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      cond = 1'($urandom);
      #1;
      expect_cycle("halt", 3'd7, 7'b0000001);
      chk("halt_opcode", 32'(opcode), 32'd0);
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      cond = 1'($urandom);
      #1;
      chk("rst_strobes",
          32'({ir_write, pc_write, mem_read, mem_write,
               reg_write, illegal_op}), 32'd0);
      if (i > 0) begin
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_buserr", 32'(bus_error), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
      end
      tick();
    end
    rst_n = 1'b1;
    mem_ready = 1'b0;
  endtask

  // fl/ml: wait cycles before ready in FETCH/MEM; >= WL means no ready.
  task automatic run_instr(input logic [5:0] op, input int fl,
                           input int ml, input bit c, input bit abort);
    int cl;
    logic [IW-1:0] instr;
    bit rdy, ld, st, ill, pw, rw;
    cl = cls_of(op);
    instr = {op, 10'($urandom)};
    ld = (cl == C_LD);
    st = (cl == C_ST);
    ill = (cl == C_ILL);

    for (int k = 0; k <= fl && k < WL; k++) begin
      rdy = (k == fl);
      mem_ready = rdy;
      mem_instr = rdy ? instr : IW'($urandom);
      cond = 1'($urandom);
      #1;
      expect_cycle("fetch", 3'd0, {rdy, rdy, 1'b1, 4'b0000});
      chk("fetch_opcode", 32'(opcode), 32'd0);
      chk("fetch_alub", 32'(alu_src_b), 32'd1);
      chk("fetch_addrsel", 32'(mem_addr_sel), 32'd0);
      if (rdy) chk("fetch_pcsrc", 32'(pc_src), 32'd0);
      tick();
    end
    if (fl >= WL) begin
      mem_ready = 1'b0;
      check_halt(3);
      do_reset(1);
      return;
    end

    mem_ready = 1'($urandom);
    #1;
    expect_cycle("decode", 3'd1, {5'b00000, ill, 1'b0});
    chk("decode_ir", 32'(ir), 32'(instr));
    chk("decode_opcode", 32'(opcode), 32'(op));
    tick();
    if (cl == C_NOOP || cl == C_ILL) begin
      mem_ready = 1'b0;
      return;
    end

    mem_ready = 1'($urandom);
    cond = c;
    #1;
    pw = (cl == C_BR) ? c : (cl == C_J || cl == C_JAL);
    rw = (cl == C_JAL);
    expect_cycle("exec", 3'd2, {1'b0, pw, 2'b00, rw, 2'b00});
    chk("exec_opcode", 32'(opcode), 32'(op));
    if (cl == C_RR) chk("exec_alub_rr", 32'(alu_src_b), 32'd0);
    if (cl == C_IMM || ld || st)
      chk("exec_alub_imm", 32'(alu_src_b), 32'd2);
    if (cl == C_BR) chk("exec_pcsrc_br", 32'(pc_src), 32'd1);
    if (cl == C_J || cl == C_JAL)
      chk("exec_pcsrc_j", 32'(pc_src), 32'd2);
    if (cl == C_JAL) chk("exec_wbsel_jal", 32'(wb_sel), 32'd2);
    tick();

    if (ld || st) begin
      for (int k = 0; k <= ml && k < WL; k++) begin
        rdy = (k == ml);
        mem_ready = rdy;
        #1;
        expect_cycle("mem", 3'd3, {2'b00, ld, st, 3'b000});
        chk("mem_addrsel", 32'(mem_addr_sel), 32'd1);
        chk("mem_opcode", 32'(opcode), 32'(op));
        tick();
        if (abort) begin
          do_reset(3);
          return;
        end
      end
      if (ml >= WL) begin
        mem_ready = 1'b0;
        check_halt(3);
        do_reset(1);
        return;
      end
    end

    if (cl == C_RR || cl == C_IMM || ld) begin
      mem_ready = 1'($urandom);
      #1;
      expect_cycle("wb", 3'd4, 7'b0000100);
      chk("wb_sel", 32'(wb_sel), ld ? 32'd1 : 32'd0);
      tick();
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    int fl, ml;

    do_reset(2);

    run_instr(6'b010010, 0, 0, 1'b0, 1'b0);
    run_instr(6'b100000, 0, 0, 1'b1, 1'b0);
    run_instr(6'b100000, 1, 0, 1'b0, 1'b0);
    run_instr(6'b111101, 0, 3, 1'b0, 1'b0);
    run_instr(6'b010000, WL, 0, 1'b0, 1'b0);
    run_instr(6'b010111, WL - 1, 0, 1'b0, 1'b0);
    run_instr(6'b111110, 0, WL, 1'b0, 1'b0);
    run_instr(6'b111011, 2, WL - 1, 1'b0, 1'b0);
    run_instr(6'b001111, 0, 0, 1'b0, 1'b0);
    run_instr(6'b111110, 0, 1, 1'b0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b0, 1'b0);
    run_instr(6'b000001, 0, 0, 1'b1, 1'b0);
    run_instr(6'b000000, 0, 0, 1'b0, 1'b0);
    run_instr(6'b111101, 0, 2, 1'b0, 1'b1);
    run_instr(6'b111001, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) op = 6'($urandom);
      else op = defs[$urandom_range(0, 15)];
      fl = ($urandom_range(0, 29) == 0) ? WL : int'($urandom_range(0, 3));
      ml = ($urandom_range(0, 19) == 0) ? WL : int'($urandom_range(0, 3));
      run_instr(op, fl, ml, 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
